regfile_wb_arbiter: RTL and testbench

- Write-back scheduler for the 32x64-bit LEGv8 register file, which has a single write port (RegWrite, writeReg, writeData).
- Two producers share that port through valid/ready handshakes:
  - port 0: execute/ALU result
  - port 1: memory load data
- Writes are buffered per port and issued strictly oldest-first, one per cycle.
- Exports a pending-write mask so the hazard unit can stall dependent reads.

---
 rtl/regfile_wb_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler for the LEGv8 register file: two buffered producers
// (ALU, load) share one registered write port, issued strictly oldest-first.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              aluValid,
    output logic              aluReady,
    input  logic [4:0]        aluReg,
    input  logic [DATA_W-1:0] aluData,
    input  logic              memValid,
    output logic              memReady,
    input  logic [4:0]        memReg,
    input  logic [DATA_W-1:0] memData,
    output logic              RegWrite,
    output logic [4:0]        writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic [31:0]       pendingMask,
    output logic              idle
);

    localparam int          D    = int'(DEPTH);
    localparam int unsigned CW   = 3;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [4:0]  ZR   = 5'(ZERO_REG);

    // A is older than B when (B - A) mod 16 falls in 1..7.
    function automatic logic is_older(input logic [3:0] tag_a, input logic [3:0] tag_b);
        logic [3:0] diff;
        diff = tag_b - tag_a;
        return (diff != 4'd0) && (diff < 4'd8);
    endfunction

    logic [1:0]        w_valid;
    logic [1:0]        w_ready;
    logic [1:0]        w_acc;
    logic [1:0]        w_enq;
    logic [1:0]        w_head;
    logic [1:0]        w_deq;
    logic [4:0]        w_in_reg  [2];
    logic [DATA_W-1:0] w_in_data [2];
    logic [CW-1:0]     w_pos     [2];
    logic [31:0]       w_pend;

    logic [CW-1:0]     r_cnt  [2];
    logic [4:0]        r_reg  [2][D];
    logic [DATA_W-1:0] r_data [2][D];
    logic [3:0]        r_tag  [2][D];
    logic [3:0]        r_seq;
    logic              r_wr_en;
    logic [4:0]        r_wr_reg;
    logic [DATA_W-1:0] r_wr_data;

    assign w_valid      = {memValid, aluValid};
    assign w_in_reg[0]  = aluReg;
    assign w_in_reg[1]  = memReg;
    assign w_in_data[0] = aluData;
    assign w_in_data[1] = memData;

    // Handshake: ready comes from registered occupancy only, never from valid.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_ready[p] = rst_n && (r_cnt[p] != FULL) && !flush;
            w_acc[p]   = w_valid[p] && w_ready[p];
            w_enq[p]   = w_acc[p] && (w_in_reg[p] != ZR);
            w_head[p]  = (r_cnt[p] != {CW{1'b0}});
            w_pos[p]   = r_cnt[p] - CW'(w_deq[p]);
        end
    end

    // Issue selection; equal tags go to the load port.
    always_comb begin
        w_deq = 2'b00;
        if (flush) begin
            w_deq = 2'b00;
        end else if (w_head[0] && w_head[1]) begin
            if (is_older(r_tag[0][0], r_tag[1][0])) begin
                w_deq = 2'b01;
            end else begin
                w_deq = 2'b10;
            end
        end else if (w_head[0]) begin
            w_deq = 2'b01;
        end else if (w_head[1]) begin
            w_deq = 2'b10;
        end else begin
            w_deq = 2'b00;
        end
    end

    // Per-port shift queues: head at slot 0, new entry lands after the survivors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                r_cnt[p] <= {CW{1'b0}};
                for (int i = 0; i < D; i++) begin
                    r_reg[p][i]  <= 5'd0;
                    r_data[p][i] <= {DATA_W{1'b0}};
                    r_tag[p][i]  <= 4'd0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (flush) begin
                    r_cnt[p] <= {CW{1'b0}};
                end else begin
                    if (w_deq[p]) begin
                        for (int i = 0; i < D - 1; i++) begin
                            r_reg[p][i]  <= r_reg[p][i+1];
                            r_data[p][i] <= r_data[p][i+1];
                            r_tag[p][i]  <= r_tag[p][i+1];
                        end
                    end
                    if (w_enq[p]) begin
                        for (int i = 0; i < D; i++) begin
                            if (CW'(i) == w_pos[p]) begin
                                r_reg[p][i]  <= w_in_reg[p];
                                r_data[p][i] <= w_in_data[p];
                                r_tag[p][i]  <= r_seq;
                            end
                        end
                    end
                    r_cnt[p] <= r_cnt[p] + CW'(w_enq[p]) - CW'(w_deq[p]);
                end
            end
        end
    end

    // Age counter: one step per edge with any enqueue, shared by same-edge pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq <= 4'd0;
        end else if (|w_enq) begin
            r_seq <= r_seq + 4'd1;
        end
    end

    // Registered write port; index/data hold when no write issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= 5'd0;
            r_wr_data <= {DATA_W{1'b0}};
        end else if (w_deq[1]) begin
            r_wr_en   <= 1'b1;
            r_wr_reg  <= r_reg[1][0];
            r_wr_data <= r_data[1][0];
        end else if (w_deq[0]) begin
            r_wr_en   <= 1'b1;
            r_wr_reg  <= r_reg[0][0];
            r_wr_data <= r_data[0][0];
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Hazard mask over every queued entry plus the write in flight.
    always_comb begin
        w_pend = 32'd0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < D; i++) begin
                if (CW'(i) < r_cnt[p]) begin
                    w_pend[r_reg[p][i]] = 1'b1;
                end else begin
                    w_pend = w_pend;
                end
            end
        end
        if (r_wr_en) begin
            w_pend[r_wr_reg] = 1'b1;
        end else begin
            w_pend = w_pend;
        end
        w_pend[ZR] = 1'b0;
    end

    assign aluReady    = w_ready[0];
    assign memReady    = w_ready[1];
    assign RegWrite    = r_wr_en;
    assign writeReg    = r_wr_reg;
    assign writeData   = r_wr_data;
    assign pendingMask = w_pend;
    assign idle        = !w_head[0] && !w_head[1] && !r_wr_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based model using unbounded ages.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        aluValid = 1'b0, memValid = 1'b0;
    logic        aluReady, memReady;
    logic [4:0]  aluReg = 5'd0, memReg = 5'd0;
    logic [63:0] aluData = 64'd0, memData = 64'd0;
    logic        RegWrite, idle;
    logic [4:0]  writeReg;
    logic [63:0] writeData;
    logic [31:0] pendingMask;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(64), .ZERO_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .aluValid(aluValid), .aluReady(aluReady), .aluReg(aluReg), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
        .pendingMask(pendingMask), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [63:0] d;
        int          age;
    } ent_t;

    ent_t        q0[$];
    ent_t        q1[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wr = 5'd0;
    logic [63:0] m_wd = 64'd0;
    int          age_ctr = 0;
    logic [63:0] rf_dut [32];

    logic        a_v = 1'b0, m_v = 1'b0, fl = 1'b0;
    logic [4:0]  a_r = 5'd0, m_r = 5'd0;
    logic [63:0] a_d = 64'd0, m_d = 64'd0;
    logic        acc0, acc1;
    int          n_checks = 0;
    int          n_fail = 0;
    int          stalls = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = 32'd0;
        foreach (q0[i]) m[q0[i].r] = 1'b1;
        foreach (q1[i]) m[q1[i].r] = 1'b1;
        if (m_we) m[m_wr] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_we = 1'b0;
        m_wr = 5'd0;
        m_wd = 64'd0;
    endtask

    // One clock: drive, compare outputs against the model, then advance the model.
    task automatic step();
        logic r0, r1;
        ent_t e;
        @(negedge clk);
        aluValid = a_v; aluReg = a_r; aluData = a_d;
        memValid = m_v; memReg = m_r; memData = m_d;
        flush = fl;
        #1;
        r0 = (q0.size() < DEPTH) && !fl;
        r1 = (q1.size() < DEPTH) && !fl;
        check_eq("aluReady", 64'(aluReady), 64'(r0));
        check_eq("memReady", 64'(memReady), 64'(r1));
        check_eq("RegWrite", 64'(RegWrite), 64'(m_we));
        check_eq("writeReg", 64'(writeReg), 64'(m_wr));
        check_eq("writeData", writeData, m_wd);
        check_eq("pendingMask", 64'(pendingMask), 64'(model_mask()));
        check_eq("idle", 64'(idle), 64'(q0.size() == 0 && q1.size() == 0 && !m_we));
        if (RegWrite) rf_dut[writeReg] = writeData;
        if (a_v && !aluReady) stalls++;
        acc0 = a_v && r0;
        acc1 = m_v && r1;
        @(posedge clk);
        if (fl) begin
            q0.delete();
            q1.delete();
            m_we = 1'b0;
        end else if (q0.size() > 0 && (q1.size() == 0 || q0[0].age < q1[0].age)) begin
            e = q0.pop_front();
            m_we = 1'b1; m_wr = e.r; m_wd = e.d;
        end else if (q1.size() > 0) begin
            e = q1.pop_front();
            m_we = 1'b1; m_wr = e.r; m_wd = e.d;
        end else begin
            m_we = 1'b0;
        end
        if ((acc0 && a_r != 5'd31) || (acc1 && m_r != 5'd31)) begin
            age_ctr++;
            if (acc0 && a_r != 5'd31) q0.push_back('{r: a_r, d: a_d, age: age_ctr});
            if (acc1 && m_r != 5'd31) q1.push_back('{r: m_r, d: m_d, age: age_ctr});
        end
    endtask

    task automatic quiet(input int n);
        a_v = 1'b0; m_v = 1'b0; fl = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int idx0, idx1;
        for (int i = 0; i < 32; i++) rf_dut[i] = 64'd0;

        #3;
        check_eq("rst_RegWrite", 64'(RegWrite), 64'd0);
        check_eq("rst_aluReady", 64'(aluReady), 64'd0);
        check_eq("rst_memReady", 64'(memReady), 64'd0);
        check_eq("rst_idle", 64'(idle), 64'd1);
        check_eq("rst_mask", 64'(pendingMask), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write
        a_v = 1'b1; a_r = 5'd12; a_d = 64'd64;
        step();
        quiet(4);
        check_eq("single_x12", rf_dut[12], 64'd64);

        // Same-edge collision on one register: load first, ALU value lands last
        a_v = 1'b1; a_r = 5'd13; a_d = 64'd69;
        m_v = 1'b1; m_r = 5'd13; m_d = 64'd250;
        step();
        quiet(4);
        check_eq("collide_x13", rf_dut[13], 64'd69);

        // Age ordering across edges
        a_v = 1'b1; a_r = 5'd5; a_d = 64'd7;
        step();
        a_v = 1'b0; m_v = 1'b1; m_r = 5'd4; m_d = 64'd25;
        step();
        quiet(4);
        check_eq("age_x5", rf_dut[5], 64'd7);
        check_eq("age_x4", rf_dut[4], 64'd25);

        // Backpressure: both ports burst so the ALU queue fills
        idx0 = 0; idx1 = 0; stalls = 0;
        for (int c = 0; c < 30 && (idx0 < 3 || idx1 < 3); c++) begin
            a_v = (idx0 < 3); a_r = 5'(7 + idx0); a_d = 64'(100 + idx0);
            m_v = (idx1 < 3); m_r = 5'(16 + idx1); m_d = 64'(200 + idx1);
            step();
            if (acc0) idx0++;
            if (acc1) idx1++;
        end
        quiet(8);
        check_eq("bp_alu_all", 64'(idx0), 64'd3);
        check_eq("bp_mem_all", 64'(idx1), 64'd3);
        check_eq("bp_stalled", 64'(stalls > 0), 64'd1);
        check_eq("bp_x9", rf_dut[9], 64'd102);
        check_eq("bp_x18", rf_dut[18], 64'd202);

        // XZR write is swallowed
        a_v = 1'b1; a_r = 5'd31; a_d = 64'hFFFF;
        step();
        quiet(3);
        check_eq("xzr_x31", rf_dut[31], 64'd0);

        // Flush drops queued entries
        a_v = 1'b1; a_r = 5'd20; a_d = 64'd1;
        m_v = 1'b1; m_r = 5'd21; m_d = 64'd2;
        step();
        a_v = 1'b0; m_v = 1'b0; fl = 1'b1;
        step();
        quiet(3);
        check_eq("flush_x20", rf_dut[20], 64'd0);
        check_eq("flush_x21", rf_dut[21], 64'd0);

        // Random traffic; producers hold a request until it is accepted
        a_v = 1'b0; m_v = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!(a_v && !acc0)) begin
                a_v = ($urandom_range(0, 3) != 0);
                a_r = 5'($urandom_range(0, 31));
                a_d = {$urandom, $urandom};
            end
            if (!(m_v && !acc1)) begin
                m_v = ($urandom_range(0, 2) != 0);
                m_r = 5'($urandom_range(0, 31));
                m_d = {$urandom, $urandom};
            end
            fl = ($urandom_range(0, 19) == 0);
            step();
        end
        fl = 1'b0;

        // Reset in the middle of a burst
        a_v = 1'b1; a_r = 5'd3; a_d = 64'd33;
        m_v = 1'b1; m_r = 5'd6; m_d = 64'd66;
        step();
        step();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_RegWrite", 64'(RegWrite), 64'd0);
        check_eq("arst_writeReg", 64'(writeReg), 64'd0);
        check_eq("arst_writeData", writeData, 64'd0);
        check_eq("arst_mask", 64'(pendingMask), 64'd0);
        check_eq("arst_aluReady", 64'(aluReady), 64'd0);
        check_eq("arst_memReady", 64'(memReady), 64'd0);
        check_eq("arst_idle", 64'(idle), 64'd1);
        model_reset();
        a_v = 1'b0; m_v = 1'b0;
        aluValid = 1'b0; memValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
